// File: rtl/apb_ic_pkg.sv
// Shared types and helpers for the APB bridge/interconnect.
package apb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_ic_state_e;

  // Slave window index of a byte address; callers zero-extend to 32 bits.
  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: byte address -> completer index and hit flag.
module apb_addr_decode
  import apb_ic_pkg::*;
#(
  parameter int NSLV      = 6,
  parameter int AW        = 12,
  parameter int SLV_SHIFT = 8,
  localparam int IW       = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic [AW-1:0] addr,
  output logic [IW-1:0] idx,
  output logic          hit
);

  logic [31:0] full_idx;

  if (AW > 32) begin : g_aw_chk
    $error("apb_addr_decode: AW must be <= 32");
  end

  assign full_idx = idx_of(32'(addr), SLV_SHIFT);
  assign hit      = (full_idx < 32'(NSLV));
  assign idx      = full_idx[IW-1:0];

endmodule

// File: rtl/apb_interconnect_n.sv
// APB bridge: one requester port, NSLV completers, full SETUP/ACCESS protocol with
// wait states, PSLVERR, decode errors and an optional ACCESS timeout.
module apb_interconnect_n
  import apb_ic_pkg::*;
#(
  parameter int NSLV      = 6,
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int SLV_SHIFT = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_addr,
  input  logic [DW-1:0]      req_wdata,
  input  logic [DW/8-1:0]    req_strb,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [NSLV-1:0]    psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  output logic [DW/8-1:0]    pstrb,
  input  logic [NSLV*DW-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = DW / 8;

  if ((64'd1 << (AW - SLV_SHIFT)) < 64'(NSLV)) begin : g_map_chk
    $error("apb_interconnect_n: address map too small for NSLV completers");
  end
  if (NSLV < 1 || NSLV > 16) begin : g_nslv_chk
    $error("apb_interconnect_n: NSLV must be 1..16");
  end
  if (DW % 8 != 0) begin : g_dw_chk
    $error("apb_interconnect_n: DW must be a multiple of 8");
  end

  apb_ic_state_e   state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]   pstrb_q, pstrb_d;

  logic [IW-1:0]   dec_idx;
  logic            dec_hit;
  logic            sel_ready, sel_err, timed_out;
  logic [DW-1:0]   sel_rdata;

  apb_addr_decode #(
    .NSLV      (NSLV),
    .AW        (AW),
    .SLV_SHIFT (SLV_SHIFT)
  ) u_dec (
    .addr (req_addr),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  // Only the selected completer's lane is looked at, so junk on idle lanes stays out.
  assign sel_ready = pready[idx_q];
  assign sel_err   = pslverr[idx_q];
  assign sel_rdata = prdata[idx_q*DW +: DW];
  assign timed_out = (TIMEOUT != 0) && (32'(wait_q) == 32'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          pwrite_d    = req_write;
          paddr_d     = req_addr;
          pwdata_d    = req_wdata;
          pstrb_d     = req_write ? req_strb : '0;
          idx_d       = dec_idx;
          wait_d      = '0;
          req_ready_d = 1'b0;
          if (dec_hit) begin
            state_d = SETUP;
            psel_d  = NSLV'(1) << dec_idx;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (sel_ready || timed_out) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_ready ? sel_err : 1'b1;
          rsp_rdata_d = (sel_ready && !pwrite_q) ? sel_rdata : '0;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        psel_d      = '0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_interconnect_n.sv
// Directed bench for apb_interconnect_n with a small configurable completer model.
module tb_apb_interconnect_n;

  localparam int NSLV = 6;
  localparam int AW   = 12;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic [3:0]        req_strb;
  logic              rsp_valid, rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic [NSLV-1:0]   psel;
  logic              penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [3:0]        pstrb;
  logic [NSLV*DW-1:0] prdata;
  logic [NSLV-1:0]   pready, pslverr;

  int          nvec = 0;
  int          nerr = 0;

  // completer model configuration
  int          slv_wait [NSLV];
  logic        slv_hang [NSLV];
  logic        slv_err  [NSLV];
  logic [31:0] slv_rdata[NSLV];
  int          acc_cnt;

  // per-transfer observations
  int          r_lat;
  logic [31:0] r_rd;
  logic        r_er, r_pw, r_pen0, r_stable;
  logic [5:0]  r_ps;
  logic [11:0] r_pa;
  logic [31:0] r_pwd;
  logic [3:0]  r_pst;

  always #5 clk = ~clk;

  apb_interconnect_n #(
    .NSLV(NSLV), .AW(AW), .DW(DW), .SLV_SHIFT(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always_ff @(posedge clk) begin
    if (penable && (|psel) && !(|(pready & psel))) acc_cnt <= acc_cnt + 1;
    else                                           acc_cnt <= 0;
  end

  // unselected lanes are driven X so any leak into the response is visible
  always_comb begin
    pready  = 'x;
    pslverr = 'x;
    prdata  = 'x;
    for (int i = 0; i < NSLV; i++) begin
      if (psel[i]) begin
        pready[i]            = penable && !slv_hang[i] && (acc_cnt >= slv_wait[i]);
        pslverr[i]           = slv_err[i];
        prdata[i*DW +: DW]   = slv_rdata[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int s, input int w, input logic h, input logic e, input logic [31:0] d);
    for (int i = 0; i < NSLV; i++) begin
      slv_wait[i] = 0; slv_hang[i] = 1'b0; slv_err[i] = 1'b0; slv_rdata[i] = 32'h0;
    end
    slv_wait[s] = w; slv_hang[s] = h; slv_err[s] = e; slv_rdata[s] = d;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
  endtask

  // Issue one request at a negedge; lat counts edges from accept to rsp_valid seen.
  task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st);
    wait_ready();
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_strb = st;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    r_lat = 1; r_ps = '0; r_pa = '0; r_pwd = '0; r_pst = '0; r_pw = 1'b0; r_pen0 = 1'b1;
    r_stable = 1'b1;
    while (!rsp_valid && r_lat < 100) begin
      if (psel != '0) begin
        if (r_ps == '0) begin
          r_pa = paddr; r_pwd = pwdata; r_pst = pstrb; r_pw = pwrite; r_pen0 = penable;
        end else if (paddr != r_pa || pwdata != r_pwd || pstrb != r_pst || pwrite != r_pw) begin
          r_stable = 1'b0;
        end
      end
      r_ps = r_ps | psel;
      @(posedge clk); @(negedge clk); r_lat++;
    end
    r_rd = rsp_rdata; r_er = rsp_err;
  endtask

  initial begin
    int pulses;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    cfg(0, 0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_psel",      64'(psel),      64'd0);
    chk("rst_penable",   64'(penable),   64'd0);
    chk("rst_paddr",     64'(paddr),     64'd0);

    // write, zero wait states
    cfg(2, 0, 1'b0, 1'b0, 32'h0);
    xfer(1'b1, 12'h204, 32'h0000_1234, 4'hF);
    chk("wr_lat",    64'(r_lat), 64'd3);
    chk("wr_err",    64'(r_er),  64'd0);
    chk("wr_rdata",  64'(r_rd),  64'd0);
    chk("wr_psel",   64'(r_ps),  64'b000100);
    chk("wr_paddr",  64'(r_pa),  64'h204);
    chk("wr_pwdata", 64'(r_pwd), 64'h1234);
    chk("wr_pstrb",  64'(r_pst), 64'hF);
    chk("wr_pwrite", 64'(r_pw),  64'd1);
    chk("wr_setup_penable", 64'(r_pen0), 64'd0);
    chk("wr_stable", 64'(r_stable), 64'd1);

    // read with three wait states
    cfg(5, 3, 1'b0, 1'b0, 32'hDEAD_BEEF);
    xfer(1'b0, 12'h510, 32'h5555_AAAA, 4'hF);
    chk("rd_lat",    64'(r_lat), 64'd6);
    chk("rd_rdata",  64'(r_rd),  64'hDEAD_BEEF);
    chk("rd_err",    64'(r_er),  64'd0);
    chk("rd_psel",   64'(r_ps),  64'b100000);
    chk("rd_pstrb",  64'(r_pst), 64'h0);
    chk("rd_pwrite", 64'(r_pw),  64'd0);
    chk("rd_stable", 64'(r_stable), 64'd1);

    // unmapped address
    cfg(0, 0, 1'b0, 1'b0, 32'h1111_1111);
    xfer(1'b0, 12'h700, 32'h0, 4'h0);
    chk("dec_lat",   64'(r_lat), 64'd1);
    chk("dec_err",   64'(r_er),  64'd1);
    chk("dec_rdata", 64'(r_rd),  64'd0);
    chk("dec_psel",  64'(r_ps),  64'd0);

    // hung completer hits the timeout: SETUP + 16 ACCESS cycles
    cfg(1, 0, 1'b1, 1'b0, 32'h7777_7777);
    xfer(1'b0, 12'h100, 32'h0, 4'h0);
    chk("to_lat",   64'(r_lat), 64'd18);
    chk("to_err",   64'(r_er),  64'd1);
    chk("to_rdata", 64'(r_rd),  64'd0);
    chk("to_psel",  64'(r_ps),  64'b000010);
    @(posedge clk); @(negedge clk);
    chk("to_psel_drop", 64'(psel), 64'd0);
    chk("to_ready",     64'(req_ready), 64'd1);
    cfg(2, 0, 1'b0, 1'b0, 32'hCAFE_0002);
    xfer(1'b0, 12'h208, 32'h0, 4'h0);
    chk("after_to_lat",   64'(r_lat), 64'd3);
    chk("after_to_rdata", 64'(r_rd),  64'hCAFE_0002);

    // PSLVERR on a read still returns data
    cfg(0, 0, 1'b0, 1'b1, 32'h0BAD_F00D);
    xfer(1'b0, 12'h00C, 32'h0, 4'h0);
    chk("slverr_err",   64'(r_er),  64'd1);
    chk("slverr_rdata", 64'(r_rd),  64'h0BAD_F00D);
    chk("slverr_lat",   64'(r_lat), 64'd3);

    // partial strobe write, one wait state, back to back after previous RESP
    cfg(4, 1, 1'b0, 1'b0, 32'h0);
    xfer(1'b1, 12'h4F8, 32'hA5A5_0F0F, 4'h3);
    chk("strb_lat",   64'(r_lat), 64'd4);
    chk("strb_pstrb", 64'(r_pst), 64'h3);
    chk("strb_psel",  64'(r_ps),  64'b010000);
    chk("strb_err",   64'(r_er),  64'd0);

    // reset while in ACCESS drops the transfer
    cfg(3, 0, 1'b1, 1'b0, 32'h0);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h300;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("mid_penable", 64'(penable), 64'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_ready",   64'(req_ready), 64'd1);
    chk("mid_rst_psel",    64'(psel),      64'd0);
    chk("mid_rst_penable", 64'(penable),   64'd0);
    chk("mid_rst_rsp",     64'(rsp_valid), 64'd0);
    chk("mid_rst_paddr",   64'(paddr),     64'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("mid_rst_no_rsp", 64'(pulses), 64'd0);
    cfg(3, 0, 1'b0, 1'b0, 32'h3333_0303);
    xfer(1'b0, 12'h3FC, 32'h0, 4'h0);
    chk("post_rst_lat",   64'(r_lat), 64'd3);
    chk("post_rst_rdata", 64'(r_rd),  64'h3333_0303);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
